// File: rtl/rle_decode.sv
// RLE decompressor: reads (count, symbol) byte pairs over SRAM port A,
// expands each run and writes the packed plaintext frame back.
module rle_decode #(
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       rle_addr,
    input  logic [31:0]       rle_size,
    input  logic [31:0]       message_addr,
    output logic [31:0]       message_size,
    output logic              done,
    output logic              error,
    output logic              port_A_clk,
    output logic [ADDR_W-1:0] port_A_addr,
    output logic              port_A_we,
    output logic [31:0]       port_A_data_in,
    input  logic [31:0]       port_A_data_out
);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_LATCH, S_EXPAND, S_WRITE, S_FLUSH, S_DONE
    } state_t;

    state_t            r_state,     w_state_nx;
    logic [31:0]       r_rd_addr,   w_rd_addr_nx;
    logic [31:0]       r_wr_addr,   w_wr_addr_nx;
    logic [31:0]       r_pairs,     w_pairs_nx;
    logic [15:0]       r_hi_pair,   w_hi_pair_nx;
    logic              r_pair_idx,  w_pair_idx_nx;
    logic              r_word_used, w_word_used_nx;
    logic [7:0]        r_cnt,       w_cnt_nx;
    logic [7:0]        r_sym,       w_sym_nx;
    logic [31:0]       r_pack,      w_pack_nx;
    logic [1:0]        r_pack_n,    w_pack_n_nx;
    logic [31:0]       r_msg_size,  w_msg_size_nx;
    logic              r_done,      w_done_nx;
    logic              r_error,     w_error_nx;
    logic              r_we,        w_we_nx;
    logic [ADDR_W-1:0] r_addr,      w_addr_nx;
    logic [31:0]       r_din,       w_din_nx;

    logic              w_emit;
    logic              w_pair_end;
    logic              w_full;
    logic [31:0]       w_pack_ins;
    logic [31:0]       w_pack_cur;
    logic [1:0]        w_n_after;
    logic              w_unused;

    assign port_A_clk     = clk;
    assign port_A_addr    = r_addr;
    assign port_A_we      = r_we;
    assign port_A_data_in = r_din;
    assign message_size   = r_msg_size;
    assign done           = r_done;
    assign error          = r_error;

    // Only the low ADDR_W address bits reach the SRAM; wrap is intentional.
    assign w_unused = ^{1'b0, r_rd_addr[31:ADDR_W], r_wr_addr[31:ADDR_W]};

    // Per-cycle expansion helpers for the active pair.
    assign w_emit     = (r_cnt != 8'd0);
    assign w_pair_end = (r_cnt <= 8'd1);
    assign w_full     = w_emit && (r_pack_n == 2'd3);
    assign w_pack_ins = r_pack | ({24'd0, r_sym} << {r_pack_n, 3'b000});
    assign w_pack_cur = w_emit ? w_pack_ins : r_pack;
    assign w_n_after  = w_emit ? (r_pack_n + 2'd1) : r_pack_n;

    // Registers, including the registered SRAM port and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_rd_addr   <= 32'd0;
            r_wr_addr   <= 32'd0;
            r_pairs     <= 32'd0;
            r_hi_pair   <= 16'd0;
            r_pair_idx  <= 1'b0;
            r_word_used <= 1'b0;
            r_cnt       <= 8'd0;
            r_sym       <= 8'd0;
            r_pack      <= 32'd0;
            r_pack_n    <= 2'd0;
            r_msg_size  <= 32'd0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_din       <= 32'd0;
        end else begin
            r_state     <= w_state_nx;
            r_rd_addr   <= w_rd_addr_nx;
            r_wr_addr   <= w_wr_addr_nx;
            r_pairs     <= w_pairs_nx;
            r_hi_pair   <= w_hi_pair_nx;
            r_pair_idx  <= w_pair_idx_nx;
            r_word_used <= w_word_used_nx;
            r_cnt       <= w_cnt_nx;
            r_sym       <= w_sym_nx;
            r_pack      <= w_pack_nx;
            r_pack_n    <= w_pack_n_nx;
            r_msg_size  <= w_msg_size_nx;
            r_done      <= w_done_nx;
            r_error     <= w_error_nx;
            r_we        <= w_we_nx;
            r_addr      <= w_addr_nx;
            r_din       <= w_din_nx;
        end
    end

    // Next-state and next-output logic; we defaults low every cycle.
    always_comb begin
        w_state_nx     = r_state;
        w_rd_addr_nx   = r_rd_addr;
        w_wr_addr_nx   = r_wr_addr;
        w_pairs_nx     = r_pairs;
        w_hi_pair_nx   = r_hi_pair;
        w_pair_idx_nx  = r_pair_idx;
        w_word_used_nx = r_word_used;
        w_cnt_nx       = r_cnt;
        w_sym_nx       = r_sym;
        w_pack_nx      = r_pack;
        w_pack_n_nx    = r_pack_n;
        w_msg_size_nx  = r_msg_size;
        w_done_nx      = r_done;
        w_error_nx     = r_error;
        w_we_nx        = 1'b0;
        w_addr_nx      = r_addr;
        w_din_nx       = r_din;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_wr_addr_nx  = message_addr;
                    w_pairs_nx    = {1'b0, rle_size[31:1]};
                    w_msg_size_nx = 32'd0;
                    w_done_nx     = 1'b0;
                    w_error_nx    = rle_size[0];
                    w_pack_nx     = 32'd0;
                    w_pack_n_nx   = 2'd0;
                    if (rle_size[31:1] == 31'd0) begin
                        w_state_nx = S_DONE;
                        w_done_nx  = 1'b1;
                    end else begin
                        w_state_nx   = S_READ;
                        w_addr_nx    = rle_addr[ADDR_W-1:0];
                        w_rd_addr_nx = rle_addr + 32'd4;
                    end
                end
            end
            S_READ: begin
                w_state_nx = S_LATCH;
            end
            S_LATCH: begin
                w_cnt_nx       = port_A_data_out[7:0];
                w_sym_nx       = port_A_data_out[15:8];
                w_hi_pair_nx   = port_A_data_out[31:16];
                w_pair_idx_nx  = 1'b0;
                w_word_used_nx = 1'b0;
                w_state_nx     = S_EXPAND;
            end
            S_EXPAND: begin
                if (w_emit) begin
                    w_msg_size_nx = r_msg_size + 32'd1;
                    w_pack_nx     = w_pack_ins;
                    w_pack_n_nx   = w_n_after;
                end else begin
                    w_error_nx = 1'b1;
                end
                if (w_full) begin
                    w_we_nx      = 1'b1;
                    w_addr_nx    = r_wr_addr[ADDR_W-1:0];
                    w_din_nx     = w_pack_ins;
                    w_wr_addr_nx = r_wr_addr + 32'd4;
                    w_pack_nx    = 32'd0;
                    w_pack_n_nx  = 2'd0;
                    w_state_nx   = S_WRITE;
                end
                if (!w_pair_end) begin
                    w_cnt_nx = r_cnt - 8'd1;
                end else begin
                    w_pairs_nx = r_pairs - 32'd1;
                    if (r_pairs == 32'd1) begin
                        if (!w_full) begin
                            if (w_n_after != 2'd0) begin
                                w_we_nx      = 1'b1;
                                w_addr_nx    = r_wr_addr[ADDR_W-1:0];
                                w_din_nx     = w_pack_cur;
                                w_wr_addr_nx = r_wr_addr + 32'd4;
                                w_state_nx   = S_FLUSH;
                            end else begin
                                w_state_nx = S_DONE;
                                w_done_nx  = 1'b1;
                            end
                        end
                    end else if (!r_pair_idx) begin
                        w_cnt_nx      = r_hi_pair[7:0];
                        w_sym_nx      = r_hi_pair[15:8];
                        w_pair_idx_nx = 1'b1;
                    end else begin
                        w_word_used_nx = 1'b1;
                        if (!w_full) begin
                            w_state_nx   = S_READ;
                            w_addr_nx    = r_rd_addr[ADDR_W-1:0];
                            w_rd_addr_nx = r_rd_addr + 32'd4;
                        end
                    end
                end
            end
            S_WRITE: begin
                if (r_pairs == 32'd0) begin
                    w_state_nx = S_DONE;
                    w_done_nx  = 1'b1;
                end else if (r_word_used) begin
                    w_state_nx   = S_READ;
                    w_addr_nx    = r_rd_addr[ADDR_W-1:0];
                    w_rd_addr_nx = r_rd_addr + 32'd4;
                end else begin
                    w_state_nx = S_EXPAND;
                end
            end
            S_FLUSH: begin
                w_state_nx = S_DONE;
                w_done_nx  = 1'b1;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rle_decode.sv
// Randomized self-checking bench for rle_decode with an SRAM model and a
// byte-level expansion reference model.
module tb_rle_decode;

    localparam int unsigned ADDR_W = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [31:0]       rle_addr, rle_size, message_addr;
    logic [31:0]       message_size;
    logic              done, error, port_A_clk, port_A_we;
    logic [ADDR_W-1:0] port_A_addr;
    logic [31:0]       port_A_data_in, port_A_data_out;

    always #5 clk = ~clk;

    rle_decode #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .rle_addr(rle_addr), .rle_size(rle_size), .message_addr(message_addr),
        .message_size(message_size), .done(done), .error(error),
        .port_A_clk(port_A_clk), .port_A_addr(port_A_addr), .port_A_we(port_A_we),
        .port_A_data_in(port_A_data_in), .port_A_data_out(port_A_data_out)
    );

    // SRAM model: 1-cycle read latency, plus a backdoor load port.
    logic [31:0] mem [0:16383];
    logic        ld_en = 1'b0;
    logic [13:0] ld_idx;
    logic [31:0] ld_data;
    always @(posedge clk) begin
        if (ld_en) mem[ld_idx] <= ld_data;
        else if (port_A_we) mem[port_A_addr[15:2]] <= port_A_data_in;
        port_A_data_out <= mem[port_A_addr[15:2]];
    end

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [7:0]  src_q[$];
    logic [31:0] exp_size;
    logic        exp_err;
    int          vectors = 0;
    int          miscompares = 0;
    bit          mon_en = 1'b0;
    wr_t         mon_e;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    // Every write cycle must match the next expected (address, word).
    always @(negedge clk) begin
        if (mon_en && port_A_we) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: addr 0x%04h data 0x%08h, required no write",
                         port_A_addr, port_A_data_in);
            end else begin
                mon_e = exp_q.pop_front();
                check32("wr_addr", {16'd0, port_A_addr}, {16'd0, mon_e.addr});
                check32("wr_data", port_A_data_in, mon_e.data);
            end
        end
    end

    // Reference: expand pairs into a byte stream, then pack little-endian.
    task automatic build_model(input logic [31:0] rs, input logic [31:0] ma);
        logic [7:0]  outb[$];
        logic [31:0] word;
        logic [31:0] a;
        int          nw;
        exp_q.delete();
        exp_err = rs[0];
        for (int p = 0; p < int'(rs / 2); p++) begin
            if (src_q[2*p] == 8'd0) exp_err = 1'b1;
            for (int k = 0; k < int'(src_q[2*p]); k++) outb.push_back(src_q[2*p+1]);
        end
        exp_size = 32'(outb.size());
        nw = (outb.size() + 3) / 4;
        for (int i = 0; i < nw; i++) begin
            word = 32'd0;
            for (int k = 0; k < 4; k++)
                if (4*i + k < outb.size()) word = word | (32'(outb[4*i+k]) << (8*k));
            a = ma + 32'(4*i);
            exp_q.push_back('{addr: a[15:0], data: word});
        end
    endtask

    task automatic load_word(input logic [13:0] idx, input logic [31:0] d);
        ld_en   = 1'b1;
        ld_idx  = idx;
        ld_data = d;
        @(posedge clk); #1;
        ld_en   = 1'b0;
    endtask

    // Pad the source, build the model and place the frame in SRAM.
    task automatic prep(input logic [31:0] ra, input logic [31:0] rs, input logic [31:0] ma);
        logic [31:0] a;
        while ((src_q.size() % 4) != 0 || src_q.size() < int'(rs)) src_q.push_back(8'($urandom));
        build_model(rs, ma);
        for (int w = 0; w < src_q.size() / 4; w++) begin
            a = ra + 32'(4*w);
            load_word(a[15:2], {src_q[4*w+3], src_q[4*w+2], src_q[4*w+1], src_q[4*w]});
        end
    endtask

    // Start the decode, optionally poke a stray start mid-run, then check results.
    task automatic exec(input logic [31:0] ra, input logic [31:0] rs, input logic [31:0] ma,
                        input bit poke);
        int cyc;
        rle_addr = ra; rle_size = rs; message_addr = ma;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (poke && rs >= 32'd2) begin
            @(posedge clk); #1;
            start = 1'b1; rle_addr = $urandom; rle_size = 32'd0; message_addr = $urandom;
            @(posedge clk); #1;
            start = 1'b0;
        end
        cyc = 0;
        while (!done && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: done=%0b after %0d cycles, required 1", done, cyc);
        end
        if (rs < 32'd2) check32("done_latency", 32'(cyc), 32'd0);
        check32("message_size", message_size, exp_size);
        check32("error", {31'd0, error}, {31'd0, exp_err});
        repeat (3) begin @(posedge clk); #1; end
        check32("writes_left", 32'(exp_q.size()), 32'd0);
        check32("done_held", {31'd0, done}, 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0;
        rle_addr = 32'd0; rle_size = 32'd0; message_addr = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check32("rst_done", {31'd0, done}, 32'd0);
        check32("rst_error", {31'd0, error}, 32'd0);
        check32("rst_msize", message_size, 32'd0);
        check32("rst_we", {31'd0, port_A_we}, 32'd0);
        check32("rst_addr", {16'd0, port_A_addr}, 32'd0);
        check32("rst_din", port_A_data_in, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        mon_en = 1'b1;

        // (3,'B'),(2,'A')
        src_q = '{8'h03, 8'h42, 8'h02, 8'h41};
        prep(32'h1000, 32'd4, 32'h8000);
        check32("pin1_w0", exp_q[0].data, 32'h41424242);
        check32("pin1_w1", exp_q[1].data, 32'h00000041);
        check32("pin1_size", exp_size, 32'd5);
        exec(32'h1000, 32'd4, 32'h8000, 1'b0);

        // single pair of 8 x 0x7E, upper half of the word is junk
        src_q = '{8'h08, 8'h7E, 8'h05, 8'h99};
        prep(32'h1010, 32'd2, 32'h8100);
        check32("pin2_nw", 32'(exp_q.size()), 32'd2);
        check32("pin2_w1", exp_q[1].data, 32'h7E7E7E7E);
        exec(32'h1010, 32'd2, 32'h8100, 1'b1);

        // empty frame
        src_q.delete();
        prep(32'h1020, 32'd0, 32'h8200);
        exec(32'h1020, 32'd0, 32'h8200, 1'b0);

        // zero count then (1, 0x55)
        src_q = '{8'h00, 8'h33, 8'h01, 8'h55};
        prep(32'h1030, 32'd4, 32'h8300);
        check32("pin4_err", {31'd0, exp_err}, 32'd1);
        check32("pin4_w0", exp_q[0].data, 32'h00000055);
        exec(32'h1030, 32'd4, 32'h8300, 1'b0);

        // max runs
        src_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        prep(32'h1040, 32'd4, 32'h9000);
        check32("pin5_nw", 32'(exp_q.size()), 32'd128);
        check32("pin5_last", exp_q[127].data, 32'h0000FFFF);
        check32("pin5_size", exp_size, 32'd510);
        exec(32'h1040, 32'd4, 32'h9000, 1'b0);

        // odd size: trailing byte ignored, error raised
        src_q = '{8'h02, 8'h11, 8'h01, 8'h22, 8'h07, 8'h00, 8'h00, 8'h00};
        prep(32'h1050, 32'd5, 32'h8400);
        exec(32'h1050, 32'd5, 32'h8400, 1'b0);

        // destination wraps modulo 2^ADDR_W
        src_q = '{8'h09, 8'hAB, 8'h02, 8'hCD};
        prep(32'h0003_1060, 32'd4, 32'h0001_FFF8);
        exec(32'h0003_1060, 32'd4, 32'h0001_FFF8, 1'b0);

        // reset during expansion, then a clean decode
        src_q = '{8'hC8, 8'h5A, 8'h40, 8'hA5};
        prep(32'h1070, 32'd4, 32'hA000);
        rle_addr = 32'h1070; rle_size = 32'd4; message_addr = 32'hA000;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) begin @(posedge clk); #1; end
        for (int i = 0; i < 8 && port_A_we; i++) begin @(posedge clk); #1; end
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        check32("mid_rst_we", {31'd0, port_A_we}, 32'd0);
        check32("mid_rst_done", {31'd0, done}, 32'd0);
        check32("mid_rst_msize", message_size, 32'd0);
        check32("mid_rst_error", {31'd0, error}, 32'd0);
        reset = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        build_model(32'd4, 32'hA000);
        exec(32'h1070, 32'd4, 32'hA000, 1'b0);

        // random frames
        for (int t = 0; t < 40; t++) begin
            logic [31:0] rs, ra, ma;
            rs = 32'($urandom_range(0, 24));
            src_q.delete();
            for (int i = 0; i < int'(rs); i++) begin
                if ((i % 2) == 0)
                    src_q.push_back(($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 12)));
                else
                    src_q.push_back(8'($urandom));
            end
            ra = {16'($urandom), 16'h1000 + 16'(4 * $urandom_range(0, 63))};
            ma = {16'($urandom), 16'h4000 + 16'(4 * $urandom_range(0, 255))};
            prep(ra, rs, ma);
            exec(ra, rs, ma, t[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
